// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and op-class helpers for the iterative MDU
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIN} mdu_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-divide step
module mdu_divstep #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtract is taken the true difference is below the divisor, so W bits suffice.
  assign diff    = shifted[W-1:0] - divisor;
  assign rem_out = q_bit ? diff : shifted[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit with HI/LO result registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         zf,
  output logic         dz
);

  localparam int CNT_W = $clog2(W + 1);

  mdu_state_t     state;
  logic [1:0]     op_r;
  logic [W-1:0]   a_r, b_r, mag;
  logic [2*W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic           neg_res, neg_rem;

  logic           a_neg, b_neg, is_div;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     msum;
  logic [W-1:0]   rem_next;
  logic           q_bit;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   res_hi, res_lo;
  logic           res_dz;

  assign is_div = op_is_div(op_r);
  assign a_neg  = op_is_signed(op_r) & a_r[W-1];
  assign b_neg  = op_is_signed(op_r) & b_r[W-1];
  assign abs_a  = a_neg ? -a_r : a_r;
  assign abs_b  = b_neg ? -b_r : b_r;

  // Multiply: multiplier sits in acc low half and shifts out LSB-first.
  assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag} : {(W+1){1'b0}});

  mdu_divstep #(.W(W)) u_divstep (
    .rem_in  (acc[2*W-1:W]),
    .bit_in  (acc[W-1]),
    .divisor (mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign prod_fix = neg_res ? -acc : acc;

  always_comb begin
    res_hi = prod_fix[2*W-1:W];
    res_lo = prod_fix[W-1:0];
    res_dz = 1'b0;
    if (is_div) begin
      if (b_r == '0) begin
        res_hi = a_r;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
        res_lo = neg_res ? -acc[W-1:0] : acc[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      mag     <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      zf      <= 1'b1;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= in_a;
            b_r   <= in_b;
            dz    <= 1'b0;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          mag     <= is_div ? abs_b : abs_a;
          acc     <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
          cnt     <= CNT_W'(W);
          state   <= ITER;
        end
        ITER: begin
          if (is_div) acc <= {rem_next, acc[W-2:0], q_bit};
          else        acc <= {msum, acc[W-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          dz    <= res_dz;
          zf    <= ({res_hi, res_lo} == '0);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized scoreboard bench for mdu_iter at W=32 and W=8
module tb_mdu_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zf;
    logic        dz;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, start8 = 1'b0;
  logic [1:0]  op32 = 2'b00, op8 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, zf32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, zf8, dz8;
  logic [7:0]  hi8, lo8;

  mdu_iter #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .in_a(a32), .in_b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .zf(zf32), .dz(dz32)
  );

  mdu_iter #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .in_a(a8), .in_b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .zf(zf8), .dz(dz8)
  );

  int   n_vec = 0, n_err = 0, cyc = 0;
  exp_t q32[$], q8[$];
  logic prev_done32 = 1'b0, prev_done8 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input logic [31:0] x, input int w);
    longint v;
    v = longint'({32'b0, x});
    if (x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: plain integer arithmetic on the architectural definition of each op.
  function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi);
    exp_t e;
    logic [31:0] m, a, b;
    logic [63:0] p, tq, tr;
    longint sa, sb;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a  = ai & m;
    b  = bi & m;
    sa = sext(a, w);
    sb = sext(b, w);
    e.dz = 1'b0;
    e.stamp = 0;
    case (o)
      2'b00, 2'b01: begin
        if (o == 2'b00) p = 64'(sa * sb);
        else            p = {32'b0, a} * {32'b0, b};
        tq = p >> w;
        e.hi = tq[31:0] & m;
        e.lo = p[31:0] & m;
      end
      default: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = m;
          e.dz = 1'b1;
        end else begin
          if (o == 2'b10) begin
            tq = 64'(sa / sb);
            tr = 64'(sa % sb);
          end else begin
            tq = {32'b0, a} / {32'b0, b};
            tr = {32'b0, a} % {32'b0, b};
          end
          e.lo = tq[31:0] & m;
          e.hi = tr[31:0] & m;
        end
      end
    endcase
    e.zf = (e.hi == 0) && (e.lo == 0);
    return e;
  endfunction

  task automatic issue(input bit sel, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit track);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while ((sel ? busy8 : busy32) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: busy still %0d after %0d cycles, required 0", 1, t);
    end
    if (sel) begin
      op8 = o; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      op32 = o; a32 = a; b32 = b; start32 = 1'b1;
    end
    if (track) begin
      e = model(sel ? 8 : 32, o, a, b);
      e.stamp = cyc + 1;
      if (sel) q8.push_back(e);
      else     q32.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return (32'd1 << (w - 1));
      2: return m;
      3: return 32'd1;
      default: return $urandom() & m;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done32) begin
        if (q32.size() == 0) begin
          check("unexpected_done32", 32'(done32), 32'd0);
        end else begin
          e = q32.pop_front();
          check("hi32", hi32, e.hi);
          check("lo32", lo32, e.lo);
          check("zf32", 32'(zf32), 32'(e.zf));
          check("dz32", 32'(dz32), 32'(e.dz));
          check("latency32", 32'(cyc - e.stamp), 32'd34);
        end
        if (prev_done32) check("done32_width", 32'(prev_done32), 32'd0);
      end
      if (done8) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          check("hi8", {24'b0, hi8}, e.hi);
          check("lo8", {24'b0, lo8}, e.lo);
          check("zf8", 32'(zf8), 32'(e.zf));
          check("dz8", 32'(dz8), 32'(e.dz));
          check("latency8", 32'(cyc - e.stamp), 32'd10);
        end
        if (prev_done8) check("done8_width", 32'(prev_done8), 32'd0);
      end
    end
    prev_done32 = done32;
    prev_done8  = done8;
  end

  task automatic check_reset_state();
    check("rst_busy32", 32'(busy32), 32'd0);
    check("rst_done32", 32'(done32), 32'd0);
    check("rst_hi32", hi32, 32'd0);
    check("rst_lo32", lo32, 32'd0);
    check("rst_zf32", 32'(zf32), 32'd1);
    check("rst_dz32", 32'(dz32), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_hi8", {24'b0, hi8}, 32'd0);
    check("rst_lo8", {24'b0, lo8}, 32'd0);
    check("rst_zf8", 32'(zf8), 32'd1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    issue(0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1);
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    issue(0, 2'b11, 32'h0000_0007, 32'h0000_0002, 1);
    issue(0, 2'b11, 32'h0000_0064, 32'h0000_0000, 1);
    issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(0, 2'b00, 32'h0000_0000, 32'h1234_5678, 1);

    // A start pulse while busy must be ignored; the next issue lands in the done cycle.
    issue(0, 2'b01, 32'h0001_2345, 32'h0000_0777, 1);
    repeat (3) @(negedge clk);
    op32 = 2'b10; a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0003; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    issue(0, 2'b10, 32'hFFFF_FF00, 32'h0000_0007, 1);

    for (int i = 0; i < 40; i++)
      issue(0, 2'($urandom_range(0, 3)), pick(32), pick(32), 1);

    // Abandon an op mid-ITER; the reset must act without waiting for a clock edge.
    issue(0, 2'b01, 32'h7654_3210, 32'h0BAD_F00D, 0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(1, 2'b00, 32'h80, 32'h80, 1);
    issue(1, 2'b10, 32'h80, 32'hFF, 1);
    issue(1, 2'b11, 32'h55, 32'h00, 1);
    for (int i = 0; i < 30; i++)
      issue(1, 2'($urandom_range(0, 3)), pick(8), pick(8), 1);

    t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", q32.size() + q8.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
